jtkiwi_vtimer_mm: RTL and testbench

- Parametrised, multi-mode video timing generator; successor of the fixed-preset timer used by the kiwi video top.
- Produces H/V counters, blanking, syncs and render-ahead line numbers for gfx and colmix.
- Adds run-time selection between two vertical presets (60 Hz / extended 50 Hz) and a programmable render lookahead.
- Adds a frame counter and a glitch-free mode switch applied only at frame boundaries.

---
 rtl/jtkiwi_vtimer_pkg.sv | 41 ++++
 rtl/jtkiwi_vtimer_flag.sv | 33 +++
 rtl/jtkiwi_vtimer_mm.sv | 157 +++++++++++++++
 tb/tb_jtkiwi_vtimer_mm.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_vtimer_pkg.sv
// ============================================================================
// jtkiwi_vtimer_pkg - timing defaults and V/H wrap helpers for jtkiwi_vtimer_mm
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package jtkiwi_vtimer_pkg;

    typedef logic [8:0] cnt9_t;

    localparam cnt9_t DEF_HCNT_END  = 9'd383;
    localparam cnt9_t DEF_HB_START  = 9'd257;
    localparam cnt9_t DEF_HB_END    = 9'd1;
    localparam cnt9_t DEF_HS_START  = 9'd297;
    localparam cnt9_t DEF_HS_LEN    = 9'd32;
    localparam cnt9_t DEF_V_START   = 9'd8;
    localparam cnt9_t DEF_VB_START  = 9'd239;
    localparam cnt9_t DEF_VB_END    = 9'd15;
    localparam cnt9_t DEF_VS_START  = 9'd254;
    localparam cnt9_t DEF_VS_LEN    = 9'd3;
    localparam cnt9_t DEF_VCNT_END  = 9'd271;
    localparam cnt9_t DEF_VCNT_END1 = 9'd319;
    localparam cnt9_t DEF_VS_START1 = 9'd278;
    localparam int    DEF_RENDER_AHEAD = 2;

    // Folds a line number that ran past vend back into vstart..vend.
    function automatic cnt9_t vwrap(input logic [9:0] x, input cnt9_t vend, input cnt9_t vstart);
        logic [9:0] span;
        span = {1'b0, vend} - {1'b0, vstart} + 10'd1;
        return (x > {1'b0, vend}) ? 9'(x - span) : x[8:0];
    endfunction

    function automatic cnt9_t hwrap(input logic [9:0] x, input cnt9_t hend);
        logic [9:0] len;
        len = {1'b0, hend} + 10'd1;
        return (x > {1'b0, hend}) ? 9'(x - len) : x[8:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtkiwi_vtimer_flag.sv
// ============================================================================
// jtkiwi_vtimer_flag - registered set/clear flag with enable; clear has priority
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkiwi_vtimer_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic cen_i,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (cen_i) begin
            if (clr_i)
                flag_q <= 1'b0;
            else if (set_i)
                flag_q <= 1'b1;
        end
    end

    assign flag_o = flag_q;

endmodule

`default_nettype wire

// File: rtl/jtkiwi_vtimer_mm.sv
// ============================================================================
// jtkiwi_vtimer_mm - multi-mode video timer: counters, blanking, syncs, render lines
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkiwi_vtimer_mm
    import jtkiwi_vtimer_pkg::*;
#(
    parameter cnt9_t HCNT_END     = DEF_HCNT_END,
    parameter cnt9_t HB_START     = DEF_HB_START,
    parameter cnt9_t HB_END       = DEF_HB_END,
    parameter cnt9_t HS_START     = DEF_HS_START,
    parameter cnt9_t HS_LEN       = DEF_HS_LEN,
    parameter cnt9_t V_START      = DEF_V_START,
    parameter cnt9_t VB_START     = DEF_VB_START,
    parameter cnt9_t VB_END       = DEF_VB_END,
    parameter cnt9_t VS_START     = DEF_VS_START,
    parameter cnt9_t VS_LEN       = DEF_VS_LEN,
    parameter cnt9_t VCNT_END     = DEF_VCNT_END,
    parameter cnt9_t VCNT_END1    = DEF_VCNT_END1,
    parameter cnt9_t VS_START1    = DEF_VS_START1,
    parameter int    RENDER_AHEAD = DEF_RENDER_AHEAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       mode,
    output logic [8:0] H,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic       Hinit,
    output logic       Vinit,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       mode_act,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] RA0     = 10'(RENDER_AHEAD);
    localparam logic [9:0] RA1     = 10'(RENDER_AHEAD + 1);
    localparam cnt9_t      HS_CLR  = hwrap({1'b0, HS_START} + {1'b0, HS_LEN}, HCNT_END);
    localparam cnt9_t      VR_RST  = vwrap({1'b0, V_START} + RA0, VCNT_END, V_START);
    localparam cnt9_t      VR1_RST = vwrap({1'b0, V_START} + RA1, VCNT_END, V_START);

    cnt9_t      H_q, H_d;
    cnt9_t      vdump_q, vdump_d;
    cnt9_t      vrender_q, vrender_d;
    cnt9_t      vrender1_q, vrender1_d;
    logic       mode_act_q, mode_act_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       Hinit_q, Hinit_d;
    logic       Vinit_q, Vinit_d;

    cnt9_t vend, vend_d, vss, vs_clr;
    logic  line_end, frame_end;

    always_comb begin
        vend      = mode_act_q ? VCNT_END1 : VCNT_END;
        vss       = mode_act_q ? VS_START1 : VS_START;
        vs_clr    = vwrap({1'b0, vss} + {1'b0, VS_LEN}, vend, V_START);
        line_end  = (H_q == HCNT_END);
        frame_end = line_end && (vdump_q == vend);

        H_d         = line_end ? 9'd0 : H_q + 9'd1;
        vdump_d     = vdump_q;
        mode_act_d  = mode_act_q;
        frame_cnt_d = frame_cnt_q;
        if (line_end)
            vdump_d = frame_end ? V_START : vdump_q + 9'd1;
        // The preset switches only here, so a frame never changes length mid-way.
        if (frame_end) begin
            mode_act_d  = mode;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        vend_d     = mode_act_d ? VCNT_END1 : VCNT_END;
        vrender_d  = vwrap({1'b0, vdump_d} + RA0, vend_d, V_START);
        vrender1_d = vwrap({1'b0, vdump_d} + RA1, vend_d, V_START);
        Hinit_d    = (H_d == HCNT_END);
        Vinit_d    = Hinit_d && (vdump_d == vend_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H_q         <= 9'd0;
            vdump_q     <= V_START;
            vrender_q   <= VR_RST;
            vrender1_q  <= VR1_RST;
            mode_act_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            Hinit_q     <= 1'b0;
            Vinit_q     <= 1'b0;
        end else if (pxl_cen) begin
            H_q         <= H_d;
            vdump_q     <= vdump_d;
            vrender_q   <= vrender_d;
            vrender1_q  <= vrender1_d;
            mode_act_q  <= mode_act_d;
            frame_cnt_q <= frame_cnt_d;
            Hinit_q     <= Hinit_d;
            Vinit_q     <= Vinit_d;
        end
    end

    // Flags decode the current counts, so each edge lands one pixel after its match.
    jtkiwi_vtimer_flag u_lhbl (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (pxl_cen),
        .set_i  (H_q == HB_END),
        .clr_i  (H_q == HB_START),
        .flag_o (LHBL)
    );

    jtkiwi_vtimer_flag u_lvbl (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (pxl_cen),
        .set_i  ((H_q == HB_START) && (vdump_q == VB_END)),
        .clr_i  ((H_q == HB_START) && (vdump_q == VB_START)),
        .flag_o (LVBL)
    );

    jtkiwi_vtimer_flag u_hs (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (pxl_cen),
        .set_i  (H_q == HS_START),
        .clr_i  (H_q == HS_CLR),
        .flag_o (HS)
    );

    jtkiwi_vtimer_flag u_vs (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (pxl_cen),
        .set_i  ((H_q == HS_START) && (vdump_q == vss)),
        .clr_i  ((H_q == HS_START) && (vdump_q == vs_clr)),
        .flag_o (VS)
    );

    assign H         = H_q;
    assign vdump     = vdump_q;
    assign vrender   = vrender_q;
    assign vrender1  = vrender1_q;
    assign Hinit     = Hinit_q;
    assign Vinit     = Vinit_q;
    assign mode_act  = mode_act_q;
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_jtkiwi_vtimer_mm.sv
// ============================================================================
// tb_jtkiwi_vtimer_mm - scoreboard bench for jtkiwi_vtimer_mm on a shrunk raster
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtkiwi_vtimer_mm;

    localparam int HE   = 23;
    localparam int HBS  = 17;
    localparam int HBE  = 1;
    localparam int HSS  = 19;
    localparam int HSL  = 8;
    localparam int VST  = 8;
    localparam int VBS  = 20;
    localparam int VBE  = 11;
    localparam int VSS0 = 22;
    localparam int VSL  = 3;
    localparam int VE0  = 25;
    localparam int VE1  = 29;
    localparam int VSS1 = 27;
    localparam int RA   = 2;
    localparam int F0   = (HE + 1) * (VE0 - VST + 1);
    localparam int F1   = (HE + 1) * (VE1 - VST + 1);

    logic       clk = 1'b0;
    logic       rst_n, pxl_cen, mode;
    logic [8:0] H, vdump, vrender, vrender1;
    logic       Hinit, Vinit, LHBL, LVBL, HS, VS, mode_act;
    logic [7:0] frame_cnt;
    logic [50:0] obs;

    int n_cmp = 0;
    int n_err = 0;
    logic [50:0] sb[$];

    int   m_h, m_v, m_fc;
    logic m_mact, m_lhbl, m_lvbl, m_hs, m_vs;

    jtkiwi_vtimer_mm #(
        .HCNT_END(9'(HE)), .HB_START(9'(HBS)), .HB_END(9'(HBE)),
        .HS_START(9'(HSS)), .HS_LEN(9'(HSL)), .V_START(9'(VST)),
        .VB_START(9'(VBS)), .VB_END(9'(VBE)), .VS_START(9'(VSS0)),
        .VS_LEN(9'(VSL)), .VCNT_END(9'(VE0)), .VCNT_END1(9'(VE1)),
        .VS_START1(9'(VSS1)), .RENDER_AHEAD(RA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .mode(mode),
        .H(H), .vdump(vdump), .vrender(vrender), .vrender1(vrender1),
        .Hinit(Hinit), .Vinit(Vinit), .LHBL(LHBL), .LVBL(LVBL),
        .HS(HS), .VS(VS), .mode_act(mode_act), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {H, vdump, vrender, vrender1, Hinit, Vinit, LHBL, LVBL, HS, VS, mode_act, frame_cnt};

    function automatic int mvend();
        return m_mact ? VE1 : VE0;
    endfunction

    function automatic int wrapv(input int x, input int ve);
        return (x > ve) ? x - (ve - VST + 1) : x;
    endfunction

    function automatic logic [50:0] model_out();
        int ve;
        ve = mvend();
        return {9'(m_h), 9'(m_v), 9'(wrapv(m_v + RA, ve)), 9'(wrapv(m_v + RA + 1, ve)),
                m_h == HE, (m_h == HE) && (m_v == ve),
                m_lhbl, m_lvbl, m_hs, m_vs, m_mact, 8'(m_fc)};
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = VST; m_fc = 0; m_mact = 1'b0;
        m_lhbl = 1'b0; m_lvbl = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
    endtask

    task automatic model_step();
        int ve, vss, hs_clr, vs_clr;
        ve     = mvend();
        vss    = m_mact ? VSS1 : VSS0;
        hs_clr = (HSS + HSL) % (HE + 1);
        vs_clr = wrapv(vss + VSL, ve);
        if (m_h == HBS) m_lhbl = 1'b0; else if (m_h == HBE) m_lhbl = 1'b1;
        if (m_h == HBS) begin
            if (m_v == VBS) m_lvbl = 1'b0; else if (m_v == VBE) m_lvbl = 1'b1;
        end
        if (m_h == hs_clr) m_hs = 1'b0; else if (m_h == HSS) m_hs = 1'b1;
        if (m_h == HSS) begin
            if (m_v == vs_clr) m_vs = 1'b0; else if (m_v == vss) m_vs = 1'b1;
        end
        if (m_h == HE) begin
            m_h = 0;
            if (m_v == ve) begin
                m_v = VST; m_mact = mode; m_fc = (m_fc + 1) % 256;
            end else begin
                m_v = m_v + 1;
            end
        end else begin
            m_h = m_h + 1;
        end
    endtask

    // Drives one clock and queues what the outputs must read just after it.
    task automatic tick(input logic cen);
        pxl_cen = cen;
        @(posedge clk);
        if (cen && rst_n) model_step();
        sb.push_back(model_out());
        #1;
    endtask

    task automatic test_reset();
        logic [50:0] e;
        model_reset();
        sb.push_back(model_out());
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset: got %h exp %h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL reset_hold: got %h exp %h", obs, e); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_line();
        logic [50:0] e;
        for (int i = 0; i < HE; i++) begin
            tick(1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL line: got %h exp %h", obs, e); end
        end
        n_cmp++;
        if (H !== 9'(HE) || Hinit !== 1'b1) begin
            n_err++; $display("FAIL hinit_at_end: got H=%0d Hinit=%b exp H=%0d Hinit=1", H, Hinit, HE);
        end
        tick(1'b1);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL line_wrap: got %h exp %h", obs, e); end
        n_cmp++;
        if (H !== 9'd0 || vdump !== 9'(VST + 1)) begin
            n_err++; $display("FAIL vdump_step: got H=%0d v=%0d exp H=0 v=%0d", H, vdump, VST + 1);
        end
    endtask

    task automatic test_frame_mode0();
        logic [50:0] e;
        logic [7:0]  fc0;
        int n;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL frame0: got %h exp %h", obs, e); end
        end while (Vinit !== 1'b1 && n < 2 * F0);
        n_cmp++;
        if (Vinit !== 1'b1) begin n_err++; $display("FAIL vinit_timeout: got Vinit=%b exp 1", Vinit); end
        fc0 = frame_cnt;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL frame0: got %h exp %h", obs, e); end
        end while (Vinit !== 1'b1 && n < 2 * F0);
        n_cmp++;
        if (n !== F0) begin n_err++; $display("FAIL frame_len0: got %0d exp %0d", n, F0); end
        n_cmp++;
        if (frame_cnt !== fc0 + 8'd1) begin
            n_err++; $display("FAIL frame_cnt: got %0d exp %0d", frame_cnt, fc0 + 8'd1);
        end
    endtask

    task automatic test_mode_switch();
        logic [50:0] e;
        int n, vs_line;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL msw: got %h exp %h", obs, e); end
        end while (vdump !== 9'd12 && n < 2 * F0);
        mode = 1'b1;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL msw: got %h exp %h", obs, e); end
        end while (Vinit !== 1'b1 && n < 2 * F0);
        n_cmp++;
        if (mode_act !== 1'b0 || vdump !== 9'(VE0)) begin
            n_err++; $display("FAIL mode_hold: got act=%b v=%0d exp act=0 v=%0d", mode_act, vdump, VE0);
        end
        tick(1'b1);
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL msw: got %h exp %h", obs, e); end
        n_cmp++;
        if (mode_act !== 1'b1 || vdump !== 9'(VST)) begin
            n_err++; $display("FAIL mode_apply: got act=%b v=%0d exp act=1 v=%0d", mode_act, vdump, VST);
        end
        n = 1; vs_line = -1;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL msw: got %h exp %h", obs, e); end
            if (VS === 1'b1 && vs_line < 0) vs_line = int'(vdump);
        end while (Vinit !== 1'b1 && n < 2 * F1);
        n_cmp++;
        if (n !== F1 || vdump !== 9'(VE1)) begin
            n_err++; $display("FAIL frame_len1: got %0d v=%0d exp %0d v=%0d", n, vdump, F1, VE1);
        end
        n_cmp++;
        if (vs_line !== VSS1) begin n_err++; $display("FAIL vs_line1: got %0d exp %0d", vs_line, VSS1); end
    endtask

    task automatic test_render_ahead();
        logic [50:0] e;
        int n;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL ra: got %h exp %h", obs, e); end
        end while (vdump !== 9'd28 && n < 2 * F1);
        n_cmp++;
        if (vrender !== 9'd8 || vrender1 !== 9'd9) begin
            n_err++; $display("FAIL ra_mode1: got %0d/%0d exp 8/9", vrender, vrender1);
        end
        mode = 1'b0;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL ra: got %h exp %h", obs, e); end
        end while (!(vdump === 9'd24 && mode_act === 1'b0) && n < 2 * F1);
        n_cmp++;
        if (vrender !== 9'd8 || vrender1 !== 9'd9) begin
            n_err++; $display("FAIL ra_wrap24: got %0d/%0d exp 8/9", vrender, vrender1);
        end
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL ra: got %h exp %h", obs, e); end
        end while (vdump !== 9'd25 && n < 2 * F0);
        n_cmp++;
        if (vrender !== 9'd9 || vrender1 !== 9'd10) begin
            n_err++; $display("FAIL ra_wrap25: got %0d/%0d exp 9/10", vrender, vrender1);
        end
    endtask

    task automatic test_cen_pattern();
        logic [50:0] e;
        int h0;
        h0 = int'(H);
        for (int i = 0; i < 30; i++) begin
            tick((i % 3) == 0);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL cen: got %h exp %h", obs, e); end
        end
        n_cmp++;
        if (H !== 9'((h0 + 10) % (HE + 1))) begin
            n_err++; $display("FAIL cen_rate: got H=%0d exp %0d", H, (h0 + 10) % (HE + 1));
        end
    endtask

    task automatic test_async_reset();
        logic [50:0] e;
        int n;
        n = 0;
        do begin
            tick(1'b1); n++;
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL pre_rst: got %h exp %h", obs, e); end
        end while (!(vdump === 9'd15 && H === 9'd12) && n < 2 * F0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.push_back(model_out());
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_rst: got %h exp %h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL rst_hold: got %h exp %h", obs, e); end
        end
        rst_n = 1'b1;
        tick(1'b1);
        e = sb.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL resume: got %h exp %h", obs, e); end
        n_cmp++;
        if (H !== 9'd1 || vdump !== 9'(VST)) begin
            n_err++; $display("FAIL resume_cnt: got H=%0d v=%0d exp H=1 v=%0d", H, vdump, VST);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL post_rst: got %h exp %h", obs, e); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pxl_cen = 1'b0;
        mode    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_line();
        test_frame_mode0();
        test_mode_switch();
        test_render_ahead();
        test_cen_pattern();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
